// File: rtl/friscv_perf_ctrl.sv
// ---------------------------------------------------------------------------
// friscv_perf_ctrl
//
// Measurement-window controller for the bus performance counter bank.
// A window is started with a non-zero length. The controller clears the
// counter bank and lets it count for exactly that many cycles. It then
// freezes every counter into a shadow copy, which is served over a small
// valid/ready read port.
//
// Ports
//   aclk, areset     clock, asynchronous active-high reset
//   srst             synchronous active-high reset (same effect as areset)
//   cfg_window       window length in cycles, sampled when a start is taken
//   start, abort     window control pulses
//   busy             high while a window is in progress (CLEAR/RUN/SNAP)
//   done             one-cycle pulse in the cycle the snapshot is taken
//   snap_ok          shadow registers hold a completed window
//   perf_srst        clear strobe to the counter bank
//   perfs            live counters; bus i occupies [i*3*REG_W +: 3*REG_W]
//                    in the order active, sleep, stall
//   rd_valid/rd_ready/rd_addr           read request channel
//   rd_data_valid/rd_data_ready/rd_data read response channel (one deep)
// ---------------------------------------------------------------------------
module friscv_perf_ctrl #(
    parameter int REG_W  = 32,
    parameter int NB_BUS = 1,
    parameter int WIN_W  = 32,
    parameter int ADDR_W = 8
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      srst,
    input  logic [WIN_W-1:0]          cfg_window,
    input  logic                      start,
    input  logic                      abort,
    output logic                      busy,
    output logic                      done,
    output logic                      snap_ok,
    output logic                      perf_srst,
    input  logic [NB_BUS*REG_W*3-1:0] perfs,
    input  logic                      rd_valid,
    output logic                      rd_ready,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic                      rd_data_valid,
    input  logic                      rd_data_ready,
    output logic [REG_W-1:0]          rd_data
);

    localparam int NCNT = 3 * NB_BUS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        SNAP  = 2'd3
    } state_t;

    state_t           state;
    logic [WIN_W-1:0] win_len;
    logic [WIN_W-1:0] win_cnt;
    logic [REG_W-1:0] shadow [NCNT];
    logic [REG_W-1:0] rd_mux;
    logic             rd_accept;

    // Status strobes are pure decodes of the registered state, so they fall
    // together with the state on either reset. perf_srst is high for the
    // single CLEAR cycle, so the bank is zero at the start of RUN cycle 1.
    assign busy      = (state != IDLE);
    assign done      = (state == SNAP);
    assign perf_srst = (state == CLEAR);

    // Window sequencer. RUN is entered with the counter at the window length
    // and leaves when it reads 1, which gives exactly win_len RUN cycles.
    // The counter never wraps because the window always ends at 1. Abort is
    // honoured only in CLEAR and RUN. In IDLE an abort also masks a
    // simultaneous start. Once SNAP is reached the capture always completes.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state   <= IDLE;
            win_len <= '0;
            win_cnt <= '0;
            snap_ok <= 1'b0;
        end else if (srst) begin
            state   <= IDLE;
            win_len <= '0;
            win_cnt <= '0;
            snap_ok <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort && (cfg_window != '0)) begin
                        win_len <= cfg_window;
                        state   <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        win_cnt <= win_len;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        win_cnt <= win_cnt - 1'b1;
                        if (win_cnt == WIN_W'(1)) begin
                            state <= SNAP;
                        end
                    end
                end
                SNAP: begin
                    snap_ok <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Shadow bank. The flat counter index (bus*3 + kind) is also the read
    // address, and it maps directly onto REG_W slices of perfs.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < NCNT; i++) begin
                shadow[i] <= '0;
            end
        end else if (srst) begin
            for (int i = 0; i < NCNT; i++) begin
                shadow[i] <= '0;
            end
        end else if (state == SNAP) begin
            for (int i = 0; i < NCNT; i++) begin
                shadow[i] <= perfs[i*REG_W +: REG_W];
            end
        end
    end

    // Read address decode. An address beyond the last counter matches no
    // entry and falls through to zero. Because the shadow is read before the
    // SNAP edge updates it, a read taken in the SNAP cycle sees the old window.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NCNT; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_mux = shadow[i];
            end
        end
    end

    assign rd_ready  = !rd_data_valid || rd_data_ready;
    assign rd_accept = rd_valid && rd_ready;

    // One-deep response register. A new request may be taken in the same
    // cycle the current response is consumed, so reads stream one per cycle.
    // rd_data only changes on an accept, which holds it stable while the
    // consumer stalls.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rd_data_valid <= 1'b0;
            rd_data       <= '0;
        end else if (srst) begin
            rd_data_valid <= 1'b0;
            rd_data       <= '0;
        end else if (rd_accept) begin
            rd_data_valid <= 1'b1;
            rd_data       <= rd_mux;
        end else if (rd_data_ready) begin
            rd_data_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_friscv_perf_ctrl.sv
// ---------------------------------------------------------------------------
// tb_friscv_perf_ctrl
//
// Directed bench for friscv_perf_ctrl with two monitored buses. A simple
// counter bank driven by per-bus valid/ready levels sits in front of the DUT
// and is cleared by perf_srst. Expected counts are fixed by the bus pattern:
// bus0 always transfers and bus1 always stalls.
// ---------------------------------------------------------------------------
module tb_friscv_perf_ctrl;

    localparam int REG_W  = 32;
    localparam int NB_BUS = 2;
    localparam int WIN_W  = 32;
    localparam int ADDR_W = 8;
    localparam int NCNT   = 3 * NB_BUS;

    logic                      aclk;
    logic                      areset;
    logic                      srst;
    logic [WIN_W-1:0]          cfg_window;
    logic                      start;
    logic                      abort;
    logic                      busy;
    logic                      done;
    logic                      snap_ok;
    logic                      perf_srst;
    logic [NB_BUS*REG_W*3-1:0] perfs;
    logic                      rd_valid;
    logic                      rd_ready;
    logic [ADDR_W-1:0]         rd_addr;
    logic                      rd_data_valid;
    logic                      rd_data_ready;
    logic [REG_W-1:0]          rd_data;

    logic [NB_BUS-1:0]         bus_valid;
    logic [NB_BUS-1:0]         bus_ready;
    logic [REG_W-1:0]          bank [NCNT];

    int checkCount = 0;
    int errorCount = 0;

    friscv_perf_ctrl #(
        .REG_W (REG_W),
        .NB_BUS(NB_BUS),
        .WIN_W (WIN_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .srst         (srst),
        .cfg_window   (cfg_window),
        .start        (start),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .snap_ok      (snap_ok),
        .perf_srst    (perf_srst),
        .perfs        (perfs),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_addr      (rd_addr),
        .rd_data_valid(rd_data_valid),
        .rd_data_ready(rd_data_ready),
        .rd_data      (rd_data)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Counter bank stand-in: active on a transfer, sleep when idle, stall when
    // valid is blocked. The clear strobe wins over counting.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < NCNT; i++) bank[i] <= '0;
        end else if (perf_srst) begin
            for (int i = 0; i < NCNT; i++) bank[i] <= '0;
        end else begin
            for (int b = 0; b < NB_BUS; b++) begin
                if (!bus_valid[b])     bank[3*b+1] <= bank[3*b+1] + 1'b1;
                else if (bus_ready[b]) bank[3*b]   <= bank[3*b]   + 1'b1;
                else                   bank[3*b+2] <= bank[3*b+2] + 1'b1;
            end
        end
    end

    always_comb begin
        perfs = '0;
        for (int i = 0; i < NCNT; i++) perfs[i*REG_W +: REG_W] = bank[i];
    end

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1 time unit
    // after the rising edge.
    task automatic applyStimulus();
        @(posedge aclk);
        #1;
    endtask

    // Launch a window and follow it until busy falls, counting how many
    // cycles each strobe was seen high.
    task automatic runWindow(input int w, output int busyCyc, output int srstCyc,
                             output int doneCyc);
        busyCyc = 0;
        srstCyc = 0;
        doneCyc = 0;
        start = 1'b1;
        cfg_window = w;
        for (int i = 0; i < w + 20; i++) begin
            applyStimulus();
            start = 1'b0;
            if (busy) busyCyc++;
            if (perf_srst) srstCyc++;
            if (done) doneCyc++;
            if (busyCyc > 0 && !busy) break;
        end
    endtask

    task automatic readAddr(input string tag, input int addr, input int expected);
        rd_valid = 1'b1;
        rd_addr = ADDR_W'(addr);
        rd_data_ready = 1'b1;
        applyStimulus();
        rd_valid = 1'b0;
        checkOutput({tag, "_valid"}, rd_data_valid, 1);
        checkOutput(tag, rd_data, expected);
        applyStimulus();
    endtask

    int bc, sc, dc;
    logic sawDone;

    initial begin
        areset = 1'b1;
        srst = 1'b0;
        cfg_window = '0;
        start = 1'b0;
        abort = 1'b0;
        rd_valid = 1'b0;
        rd_addr = '0;
        rd_data_ready = 1'b1;
        bus_valid = 2'b11;
        bus_ready = 2'b01;
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_snap_ok", snap_ok, 0);
        checkOutput("rst_perf_srst", perf_srst, 0);
        checkOutput("rst_rd_data_valid", rd_data_valid, 0);
        checkOutput("rst_rd_data", rd_data, 0);
        checkOutput("rst_rd_ready", rd_ready, 1);

        $display("[TB] 10-cycle window");
        runWindow(10, bc, sc, dc);
        checkOutput("w10_busy_cycles", bc, 12);
        checkOutput("w10_srst_cycles", sc, 1);
        checkOutput("w10_done_cycles", dc, 1);
        checkOutput("w10_snap_ok", snap_ok, 1);
        readAddr("w10_addr0", 0, 10);
        readAddr("w10_addr1", 1, 0);
        readAddr("w10_addr2", 2, 0);
        readAddr("w10_addr3", 3, 0);
        readAddr("w10_addr4", 4, 0);
        readAddr("w10_addr5", 5, 10);

        $display("[TB] zero-length start");
        bc = 0; sc = 0; dc = 0;
        start = 1'b1;
        cfg_window = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            start = 1'b0;
            if (busy) bc++;
            if (perf_srst) sc++;
            if (done) dc++;
        end
        checkOutput("w0_busy_cycles", bc, 0);
        checkOutput("w0_srst_cycles", sc, 0);
        checkOutput("w0_done_cycles", dc, 0);

        $display("[TB] abort with start in idle");
        start = 1'b1;
        abort = 1'b1;
        cfg_window = 5;
        applyStimulus();
        start = 1'b0;
        abort = 1'b0;
        checkOutput("idle_abort_busy", busy, 0);
        applyStimulus();
        checkOutput("idle_abort_busy2", busy, 0);

        $display("[TB] 5-cycle window then aborted 100-cycle window");
        runWindow(5, bc, sc, dc);
        checkOutput("w5_busy_cycles", bc, 7);
        checkOutput("w5_done_cycles", dc, 1);
        dc = 0;
        start = 1'b1;
        cfg_window = 100;
        applyStimulus();
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus();
            if (done) dc++;
        end
        checkOutput("abort_busy_before", busy, 1);
        abort = 1'b1;
        applyStimulus();
        abort = 1'b0;
        if (done) dc++;
        checkOutput("abort_busy_after", busy, 0);
        checkOutput("abort_perf_srst", perf_srst, 0);
        checkOutput("abort_done_cycles", dc, 0);
        checkOutput("abort_snap_ok", snap_ok, 1);
        readAddr("abort_addr0", 0, 5);
        readAddr("abort_addr5", 5, 5);
        readAddr("abort_addr1", 1, 0);

        $display("[TB] out-of-range read and response backpressure");
        readAddr("oor_addr6", 6, 0);
        rd_valid = 1'b1;
        rd_addr = 0;
        rd_data_ready = 1'b0;
        applyStimulus();
        rd_addr = 4;
        checkOutput("bp_first_valid", rd_data_valid, 1);
        checkOutput("bp_first_data", rd_data, 5);
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_hold_data", rd_data, 5);
            checkOutput("bp_hold_valid", rd_data_valid, 1);
            checkOutput("bp_hold_ready", rd_ready, 0);
            applyStimulus();
        end
        checkOutput("bp_hold_data_last", rd_data, 5);
        rd_data_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", rd_ready, 1);
        applyStimulus();
        rd_valid = 1'b0;
        checkOutput("bp_second_valid", rd_data_valid, 1);
        checkOutput("bp_second_data", rd_data, 0);
        applyStimulus();
        checkOutput("bp_drained", rd_data_valid, 0);

        $display("[TB] read in the snapshot cycle");
        runWindow(7, bc, sc, dc);
        readAddr("pre_addr0", 0, 7);
        sawDone = 1'b0;
        start = 1'b1;
        cfg_window = 10;
        for (int i = 0; i < 30; i++) begin
            applyStimulus();
            start = 1'b0;
            if (done) begin
                sawDone = 1'b1;
                break;
            end
        end
        checkOutput("snap_seen_done", sawDone, 1);
        rd_valid = 1'b1;
        rd_addr = 0;
        rd_data_ready = 1'b1;
        applyStimulus();
        checkOutput("snap_read_old", rd_data, 7);
        applyStimulus();
        rd_valid = 1'b0;
        checkOutput("snap_read_new", rd_data, 10);
        applyStimulus();

        $display("[TB] asynchronous reset mid-window");
        start = 1'b1;
        cfg_window = 50;
        applyStimulus();
        start = 1'b0;
        repeat (5) applyStimulus();
        rd_valid = 1'b1;
        rd_addr = 0;
        rd_data_ready = 1'b0;
        applyStimulus();
        rd_valid = 1'b0;
        checkOutput("ar_busy_before", busy, 1);
        checkOutput("ar_rdv_before", rd_data_valid, 1);
        #2;
        areset = 1'b1;
        #1;
        checkOutput("ar_busy", busy, 0);
        checkOutput("ar_perf_srst", perf_srst, 0);
        checkOutput("ar_rd_data_valid", rd_data_valid, 0);
        checkOutput("ar_rd_data", rd_data, 0);
        checkOutput("ar_snap_ok", snap_ok, 0);
        rd_data_ready = 1'b1;
        #2;
        areset = 1'b0;
        applyStimulus();
        readAddr("ar_addr0", 0, 0);

        $display("[TB] synchronous reset mid-window");
        runWindow(4, bc, sc, dc);
        readAddr("sr_pre_addr0", 0, 4);
        start = 1'b1;
        cfg_window = 50;
        applyStimulus();
        start = 1'b0;
        repeat (5) applyStimulus();
        srst = 1'b1;
        #1;
        checkOutput("sr_busy_held", busy, 1);
        applyStimulus();
        srst = 1'b0;
        checkOutput("sr_busy", busy, 0);
        checkOutput("sr_perf_srst", perf_srst, 0);
        checkOutput("sr_snap_ok", snap_ok, 0);
        readAddr("sr_addr0", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/friscv_perf_ctrl.md
Name: friscv_perf_ctrl

Overview:
Measurement-window controller for the bus performance counter bank (active/sleep/stall, REG_W bits each, 3 per bus).
- Clears the counter bank at window start and runs a programmable cycle window.
- Snapshots all counters into shadow registers at window end.
- Serves shadow values over a one-deep valid/ready read port.
- Sits between the CSR/debug access logic and the counter bank.

Parameters:
REG_W, 32, width of each counter and of rd_data
NB_BUS, 1, number of monitored buses (3*NB_BUS counters)
WIN_W, 32, width of window length and window counter
ADDR_W, 8, read address width; must satisfy 2**ADDR_W > 3*NB_BUS

Ports:
aclk  in  1  clock
areset  in  1  asynchronous reset, active high
srst  in  1  synchronous reset, active high, same effect as areset
cfg_window  in  WIN_W  window length in cycles, sampled on accepted start
start  in  1  start pulse
abort  in  1  abort running window
busy  out  1  high in CLEAR, RUN, SNAP
done  out  1  one-cycle pulse when snapshot written
snap_ok  out  1  shadow holds a completed window
perf_srst  out  1  clear to counter bank
perfs  in  NB_BUS*REG_W*3  live counters; bus i at [i*3*REG_W +: 3*REG_W], order active, sleep, stall
rd_valid  in  1  read request
rd_ready  out  1  read request accepted
rd_addr  in  ADDR_W  counter index: bus = addr/3, kind = addr%3
rd_data_valid  out  1  response valid
rd_data_ready  in  1  response consumed
rd_data  out  REG_W  response data

Behaviour:
- Reset (areset async, or srst sync):
  - state IDLE; window counter 0; shadow all 0.
  - busy, done, snap_ok, perf_srst, rd_data_valid all 0; rd_data 0.
- FSM IDLE -> CLEAR -> RUN -> SNAP -> IDLE.
- IDLE: start=1 with cfg_window!=0 -> latch cfg_window, go CLEAR. start with cfg_window==0 is ignored; no state change.
- CLEAR (1 cycle):
  - perf_srst=1, decoded combinationally from state, so counters clear at the end of this cycle.
  - Load window counter = latched window; go RUN.
- RUN (exactly W cycles):
  - Window counter decrements each cycle; counter==1 -> SNAP.
  - Bus activity in RUN cycles 1..W is what gets measured.
- SNAP (1 cycle):
  - perfs reflects exactly the W RUN cycles; capture all 3*NB_BUS counters into shadow at the clock edge.
  - done=1 and snap_ok<=1 (registered, high from the next cycle); go IDLE.
- start while busy: ignored.
- abort in CLEAR or RUN: go IDLE next cycle; no snapshot, no done; shadow and snap_ok unchanged; perf_srst not re-asserted.
- abort in SNAP: ignored; snapshot completes.
- abort together with start in IDLE: abort wins, start dropped.
- Read port:
  - rd_ready = !rd_data_valid || rd_data_ready.
  - Accept on rd_valid && rd_ready. Next cycle rd_data_valid=1 and rd_data = shadow[rd_addr].
  - rd_addr >= 3*NB_BUS returns 0.
  - rd_data is held stable while rd_data_valid && !rd_data_ready.
  - Back-to-back reads give one response per cycle when rd_data_ready stays high.
  - Read accepted in the same cycle as the SNAP capture returns the pre-snapshot shadow value.
  - Reads are allowed in any state; they never stall the FSM.
- Window counter width WIN_W; no wrap, since a window ends at 1.

Test Plan:
- NB_BUS=2, cfg_window=10, bus0 valid=ready=1 every cycle, bus1 valid=1 ready=0 -> after done: addr0 (bus0 active)=10, addr1=0, addr2=0, addr3=0, addr5 (bus1 stall)=10; busy high exactly 12 cycles; perf_srst high 1 cycle.
- start with cfg_window=0 -> busy stays 0, no perf_srst, no done.
- Run cfg_window=5 to completion, then start cfg_window=100 and pulse abort in RUN cycle 40 -> IDLE next cycle, no done, reads still return the 5-cycle values, snap_ok=1.
- Read addr 6 with NB_BUS=2 -> rd_data=0. Read with rd_data_ready held 0 for 3 cycles -> rd_data stable, rd_ready=0, no second accept until consumed.
- Read accepted in the SNAP cycle (shadow addr0=7 before, new value 10) -> returns 7; next read returns 10.
- areset asserted mid-RUN (async, between edges) -> busy, perf_srst, rd_data_valid drop to 0 immediately; shadow=0, snap_ok=0. Repeat with srst -> same at the next edge.
